fetch_unit: RTL and testbench

Instruction fetch stage: owns the program counter, issues requests to instruction memory, and drives `instr_ID`/`pc_ID` into the decode stage that feeds the control unit. It takes redirects computed downstream from `branch`/`jal`/`jalr` resolution and applies stalls from decode. It also buffers one fetched word when decode is stalled, so memory handshakes are never lost.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode-side controls and the ID register outputs.
// The fetch unit uses the master modport; memory and decode sit on the slave side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_ID;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_ID;
  logic [31:0] pc_ID;
  logic        valid_ID;

  modport master (
    output imem_req, imem_addr, instr_ID, pc_ID, valid_ID,
    input  imem_ready, imem_rdata, stall_ID, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_ID, pc_ID, valid_ID,
    output imem_ready, imem_rdata, stall_ID, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues memory requests, applies redirects and stalls,
// and keeps a one-entry skid buffer so an accepted word is never lost while decode is stalled.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrop, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_q, valid_d;

  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

  // Request is a pure function of state so an asynchronous reset abandons it immediately.
  assign bus.imem_req  = (state_q == StFetch) || (state_q == StDrop);
  assign bus.imem_addr = addr_q;
  assign bus.instr_ID  = instr_q;
  assign bus.pc_ID     = pc_id_q;
  assign bus.valid_ID  = valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    pend_pc_d     = pend_pc_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    deliver       = 1'b0;
    deliver_instr = bus.imem_rdata;
    deliver_pc    = addr_q;

    unique case (state_q)
      StIdle: begin
        addr_d  = pc_q;
        state_d = StFetch;
      end
      StFetch: begin
        if (bus.redirect) begin
          if (bus.imem_ready) begin
            pc_d   = redirect_tgt;
            addr_d = redirect_tgt;
          end else begin
            // Address must stay stable until memory accepts, so park the target.
            pend_pc_d = redirect_tgt;
            state_d   = StDrop;
          end
        end else if (bus.imem_ready) begin
          if (bus.stall_ID) begin
            buf_instr_d = bus.imem_rdata;
            buf_pc_d    = addr_q;
            state_d     = StHold;
          end else begin
            deliver = 1'b1;
            pc_d    = addr_q + 32'd4;
            addr_d  = addr_q + 32'd4;
          end
        end
      end
      StDrop: begin
        if (bus.redirect) begin
          pend_pc_d = redirect_tgt;
        end
        if (bus.imem_ready) begin
          pc_d    = pend_pc_d;
          addr_d  = pend_pc_d;
          state_d = StFetch;
        end
      end
      StHold: begin
        if (bus.redirect) begin
          pc_d    = redirect_tgt;
          addr_d  = redirect_tgt;
          state_d = StFetch;
        end else if (!bus.stall_ID) begin
          deliver       = 1'b1;
          deliver_instr = buf_instr_q;
          deliver_pc    = buf_pc_q;
          pc_d          = buf_pc_q + 32'd4;
          addr_d        = buf_pc_q + 32'd4;
          state_d       = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ID register: redirect flush beats stall hold beats delivery beats bubble.
  always_comb begin
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    valid_d = valid_q;
    if (bus.redirect) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (bus.stall_ID) begin
      instr_d = instr_q;
    end else if (deliver) begin
      instr_d = deliver_instr;
      pc_id_d = deliver_pc;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_id_q     <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      pend_pc_q   <= pend_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pc_id_q     <= pc_id_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus a randomized run checked against an
// in-order instruction-stream model (next expected PC, restarted by each redirect).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if bus ();
  fetch_unit_if bus_w ();

  fetch_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_rdata     = mem_word(bus.imem_addr);
  assign bus_w.imem_rdata   = mem_word(bus_w.imem_addr);
  assign bus_w.imem_ready   = 1'b1;
  assign bus_w.stall_ID     = 1'b0;
  assign bus_w.redirect     = 1'b0;
  assign bus_w.redirect_pc  = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.imem_ready  = 1'b0;
    bus.stall_ID    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID, bus.pc_ID} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0}) begin
      errors++;
      $display("FAIL reset_values: got req=%b addr=%h valid=%b instr=%h pc=%h, want 0/0/0/%h/0",
               bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID, bus.pc_ID, NOP);
    end
    rst = 1'b0;
  endtask

  // After run_to(n): imem_addr = 4n and ID holds the word at 4(n-1).
  task automatic run_to(input int n);
    do_reset();
    bus.imem_ready = 1'b1;
    repeat (n + 1) tick();
  endtask

  task automatic test_reset();
    do_reset();
    bus.imem_ready = 1'b1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: got %b, want 0", bus.imem_req);
    end
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.valid_ID} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h valid=%b, want 1/00000000/0",
               bus.imem_req, bus.imem_addr, bus.valid_ID);
    end
  endtask

  task automatic test_stream();
    run_to(0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.valid_ID, bus.pc_ID, bus.instr_ID} !==
          {1'b1, 32'(4 * (i + 1)), 1'b1, 32'(4 * i), mem_word(32'(4 * i))}) begin
        errors++;
        $display("FAIL stream[%0d]: got addr=%h valid=%b pc=%h instr=%h, want addr=%h pc=%h",
                 i, bus.imem_addr, bus.valid_ID, bus.pc_ID, bus.instr_ID, 4 * (i + 1), 4 * i);
      end
    end
  endtask

  task automatic test_ready_low();
    run_to(2);
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID} !==
          {1'b1, 32'h8, 1'b0, NOP}) begin
        errors++;
        $display("FAIL ready_low_bubble[%0d]: got req=%b addr=%h valid=%b instr=%h", i,
                 bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID);
      end
    end
    bus.imem_ready = 1'b1;
    tick();
    checks++;
    if ({bus.valid_ID, bus.pc_ID, bus.instr_ID, bus.imem_addr} !==
        {1'b1, 32'h8, mem_word(32'h8), 32'hC}) begin
      errors++;
      $display("FAIL ready_low_resume: got valid=%b pc=%h instr=%h addr=%h, want 1/8/%h/c",
               bus.valid_ID, bus.pc_ID, bus.instr_ID, bus.imem_addr, mem_word(32'h8));
    end
  endtask

  task automatic test_stall();
    run_to(3);
    bus.stall_ID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.imem_req, bus.valid_ID, bus.pc_ID, bus.instr_ID} !==
          {1'b0, 1'b1, 32'h8, mem_word(32'h8)}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got req=%b valid=%b pc=%h instr=%h, want 0/1/8/%h", i,
                 bus.imem_req, bus.valid_ID, bus.pc_ID, bus.instr_ID, mem_word(32'h8));
      end
    end
    bus.stall_ID = 1'b0;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.valid_ID, bus.pc_ID, bus.instr_ID} !==
        {1'b1, 32'h10, 1'b1, 32'hC, mem_word(32'hC)}) begin
      errors++;
      $display("FAIL stall_release: got req=%b addr=%h valid=%b pc=%h instr=%h, want 1/10/1/c",
               bus.imem_req, bus.imem_addr, bus.valid_ID, bus.pc_ID, bus.instr_ID);
    end
    tick();
    checks++;
    if ({bus.imem_addr, bus.pc_ID, bus.instr_ID} !== {32'h14, 32'h10, mem_word(32'h10)}) begin
      errors++;
      $display("FAIL stall_after: got addr=%h pc=%h instr=%h, want 14/10",
               bus.imem_addr, bus.pc_ID, bus.instr_ID);
    end
  endtask

  task automatic test_redirect_pending();
    run_to(5);
    bus.imem_ready  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h103;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID, bus.pc_ID} !==
        {1'b1, 32'h14, 1'b0, NOP, 32'h10}) begin
      errors++;
      $display("FAIL redir_pend_flush: got req=%b addr=%h valid=%b instr=%h pc=%h",
               bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID, bus.pc_ID);
    end
    bus.redirect = 1'b0;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.valid_ID} !== {1'b1, 32'h14, 1'b0}) begin
      errors++;
      $display("FAIL redir_pend_stable: got req=%b addr=%h valid=%b, want 1/14/0",
               bus.imem_req, bus.imem_addr, bus.valid_ID);
    end
    bus.imem_ready = 1'b1;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID} !==
        {1'b1, 32'h100, 1'b0, NOP}) begin
      errors++;
      $display("FAIL redir_pend_drop: got req=%b addr=%h valid=%b instr=%h, want 1/100/0/nop",
               bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID);
    end
    tick();
    checks++;
    if ({bus.imem_addr, bus.valid_ID, bus.pc_ID, bus.instr_ID} !==
        {32'h104, 1'b1, 32'h100, mem_word(32'h100)}) begin
      errors++;
      $display("FAIL redir_pend_target: got addr=%h valid=%b pc=%h instr=%h, want 104/1/100",
               bus.imem_addr, bus.valid_ID, bus.pc_ID, bus.instr_ID);
    end
  endtask

  task automatic test_redirect_hold();
    run_to(2);
    bus.stall_ID = 1'b1;
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID, bus.pc_ID} !==
        {1'b1, 32'h200, 1'b0, NOP, 32'h4}) begin
      errors++;
      $display("FAIL redir_hold: got req=%b addr=%h valid=%b instr=%h pc=%h, want 1/200/0/nop/4",
               bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID, bus.pc_ID);
    end
    bus.redirect = 1'b0;
    bus.stall_ID = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.valid_ID, bus.pc_ID, bus.instr_ID} !==
        {32'h204, 1'b1, 32'h200, mem_word(32'h200)}) begin
      errors++;
      $display("FAIL redir_hold_target: got addr=%h valid=%b pc=%h instr=%h, want 204/1/200",
               bus.imem_addr, bus.valid_ID, bus.pc_ID, bus.instr_ID);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    checks++;
    if ({bus_w.imem_req, bus_w.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_first: got req=%b addr=%h, want 1/fffffffc",
               bus_w.imem_req, bus_w.imem_addr);
    end
    tick();
    checks++;
    if ({bus_w.imem_addr, bus_w.valid_ID, bus_w.pc_ID} !== {32'h0, 1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_second: got addr=%h valid=%b pc=%h, want 0/1/fffffffc",
               bus_w.imem_addr, bus_w.valid_ID, bus_w.pc_ID);
    end
    tick();
    checks++;
    if ({bus_w.imem_addr, bus_w.pc_ID, bus_w.instr_ID} !== {32'h4, 32'h0, mem_word(32'h0)}) begin
      errors++;
      $display("FAIL wrap_third: got addr=%h pc=%h instr=%h, want 4/0",
               bus_w.imem_addr, bus_w.pc_ID, bus_w.instr_ID);
    end
  endtask

  task automatic test_async_reset();
    run_to(3);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID, bus.pc_ID,
         bus_w.imem_req, bus_w.imem_addr} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL async_reset: got req=%b addr=%h valid=%b instr=%h pc=%h w_req=%b w_addr=%h",
               bus.imem_req, bus.imem_addr, bus.valid_ID, bus.instr_ID, bus.pc_ID,
               bus_w.imem_req, bus_w.imem_addr);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_next, prev_instr, prev_pc, pre_addr, r_tgt;
    logic        prev_valid, pre_req, pre_ready, r_redirect, r_stall;
    int          delivered;
    delivered = 0;
    exp_next  = 32'h0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.imem_ready  = ($urandom_range(0, 3) != 0);
      bus.stall_ID    = ($urandom_range(0, 4) == 0);
      bus.redirect    = (cyc > 2) && ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom() & 32'h0000_FFFF;
      prev_instr = bus.instr_ID;
      prev_pc    = bus.pc_ID;
      prev_valid = bus.valid_ID;
      pre_req    = bus.imem_req;
      pre_addr   = bus.imem_addr;
      pre_ready  = bus.imem_ready;
      r_redirect = bus.redirect;
      r_stall    = bus.stall_ID;
      r_tgt      = bus.redirect_pc & ~32'h3;
      tick();
      checks++;
      if (r_redirect) begin
        if ({bus.valid_ID, bus.instr_ID, bus.pc_ID} !== {1'b0, NOP, prev_pc}) begin
          errors++;
          $display("FAIL rnd_flush@%0d: got valid=%b instr=%h pc=%h, want 0/nop/%h", cyc,
                   bus.valid_ID, bus.instr_ID, bus.pc_ID, prev_pc);
        end
        exp_next = r_tgt;
      end else if (r_stall) begin
        if ({bus.valid_ID, bus.instr_ID, bus.pc_ID} !== {prev_valid, prev_instr, prev_pc}) begin
          errors++;
          $display("FAIL rnd_hold@%0d: got valid=%b instr=%h pc=%h, want %b/%h/%h", cyc,
                   bus.valid_ID, bus.instr_ID, bus.pc_ID, prev_valid, prev_instr, prev_pc);
        end
      end else if (bus.valid_ID === 1'b1) begin
        if ({bus.pc_ID, bus.instr_ID} !== {exp_next, mem_word(exp_next)}) begin
          errors++;
          $display("FAIL rnd_order@%0d: got pc=%h instr=%h, want pc=%h instr=%h", cyc,
                   bus.pc_ID, bus.instr_ID, exp_next, mem_word(exp_next));
        end
        exp_next = exp_next + 32'd4;
        delivered++;
      end else begin
        if (bus.instr_ID !== NOP) begin
          errors++;
          $display("FAIL rnd_bubble@%0d: got instr=%h valid=%b, want nop", cyc,
                   bus.instr_ID, bus.valid_ID);
        end
      end
      if (pre_req && !pre_ready) begin
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, pre_addr}) begin
          errors++;
          $display("FAIL rnd_addr_stable@%0d: got req=%b addr=%h, want 1/%h", cyc,
                   bus.imem_req, bus.imem_addr, pre_addr);
        end
      end
    end
    checks++;
    if (delivered < 500) begin
      errors++;
      $display("FAIL rnd_progress: got %0d deliveries, want at least 500", delivered);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.imem_ready  = 1'b0;
    bus.stall_ID    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_ready_low();
    test_stall();
    test_redirect_pending();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
